// File: rtl/serial_adder_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. Latches two WIDTH-bit operands,
//               streams them LSB-first through a two-half-adder full-add
//               stage, and assembles the sum right-aligned in a shift
//               register. Flags busy while shifting and pulses done once.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8  // operand width, legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter is one bit wider than needed to index WIDTH-1 so it cannot wrap.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q;

  logic w_accept;
  logic w_last;
  logic w_ha1_s, w_ha1_c, w_ha2_s, w_ha2_c;
  logic w_s, w_c_next;

  // Start is honoured only outside the shift phase.
  assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_last   = (cnt_q == C_CNT_LAST);

  // Two cascaded half adders plus an OR form the full-add of one bit position.
  assign w_ha1_s  = a_q[0] ^ b_q[0];
  assign w_ha1_c  = a_q[0] & b_q[0];
  assign w_ha2_s  = w_ha1_s ^ carry_q;
  assign w_ha2_c  = w_ha1_s & carry_q;
  assign w_s      = w_ha2_s;
  assign w_c_next = w_ha1_c | w_ha2_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: DONE chains straight into SHIFT when start is held.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = w_accept ? S_SHIFT : S_IDLE;
      S_SHIFT: state_d = w_last   ? S_DONE  : S_SHIFT;
      S_DONE:  state_d = w_accept ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: bit outputs are forced low whenever they are not valid.
  always_comb begin
    busy      = (state_q == S_SHIFT);
    done      = (state_q == S_DONE);
    bit_valid = busy;
    bit_a     = busy & a_q[0];
    bit_b     = busy & b_q[0];
    sum       = sum_q;
    cout      = cout_q;
  end

  // Datapath: load on accept, shift one bit per SHIFT cycle, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (w_accept) begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (state_q == S_SHIFT) begin
      a_q     <= {1'b0, a_q[WIDTH-1:1]};
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      sum_q   <= {w_s, sum_q[WIDTH-1:1]};
      carry_q <= w_c_next;
      if (w_last) cout_q <= w_c_next;
      else        cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_serial_adder_ctrl
// Description : Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             bit_a, bit_b, bit_valid, busy, done, cout;
  logic [WIDTH-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bit_a     (bit_a),
    .bit_b     (bit_b),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk the eight SHIFT cycles starting at the current negedge; ends at the
  // DONE-cycle negedge. Optionally re-pulses start with junk operands.
  task automatic do_shift(input logic [7:0] oa, input logic [7:0] ob, input int inject);
    for (int i = 0; i < WIDTH; i++) begin
      check($sformatf("busy[%0d]", i), busy, 1'b1);
      check($sformatf("bit_valid[%0d]", i), bit_valid, 1'b1);
      check($sformatf("done_low[%0d]", i), done, 1'b0);
      check($sformatf("bit_a[%0d]", i), bit_a, oa[i]);
      check($sformatf("bit_b[%0d]", i), bit_b, ob[i]);
      if (i == 0) begin
        check("sum_cleared", sum, 8'h00);
        check("cout_cleared", cout, 1'b0);
      end
      if (i == inject) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end else if (i == inject + 1) begin
        start = 1'b0; a = 8'h77; b = 8'h66;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_done(input logic [7:0] es, input logic ec);
    check("done", done, 1'b1);
    check("busy_in_done", busy, 1'b0);
    check("bit_valid_in_done", bit_valid, 1'b0);
    check("bit_a_idle", bit_a, 1'b0);
    check("bit_b_idle", bit_b, 1'b0);
    check("sum", sum, es);
    check("cout", cout, ec);
  endtask

  task automatic check_hold(input logic [7:0] es, input logic ec);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    check("sum_hold", sum, es);
    check("cout_hold", cout, ec);
  endtask

  task automatic op(input logic [7:0] oa, input logic [7:0] ob, input logic [7:0] es, input logic ec);
    start = 1'b1; a = oa; b = ob;
    @(negedge clk);
    start = 1'b0; a = ~oa; b = ~ob;
    do_shift(oa, ob, -1);
    check_done(es, ec);
    @(negedge clk);
    check_hold(es, ec);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy_async", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bit_valid", bit_valid, 1'b0);
    check("rst_bit_a", bit_a, 1'b0);
    check("rst_bit_b", bit_b, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);

    // Start held high across the first edge after reset release.
    rst_n = 1'b1; start = 1'b1; a = 8'h5A; b = 8'h33;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    do_shift(8'h5A, 8'h33, -1);
    check_done(8'h8D, 1'b0);
    @(negedge clk);
    check_hold(8'h8D, 1'b0);

    // Boundary operands.
    op(8'hFF, 8'h01, 8'h00, 1'b1);
    op(8'hFF, 8'hFF, 8'hFE, 1'b1);
    op(8'h00, 8'h00, 8'h00, 1'b0);

    // Start re-pulsed mid-operation and operands changed: both ignored.
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    do_shift(8'h10, 8'h20, 2);
    check_done(8'h30, 1'b0);
    @(negedge clk);
    check_hold(8'h30, 1'b0);

    // Start held in DONE chains directly into a new operation.
    start = 1'b1; a = 8'h0F; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    do_shift(8'h0F, 8'h01, -1);
    check_done(8'h10, 1'b0);
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    do_shift(8'h01, 8'h02, -1);
    check_done(8'h03, 1'b0);
    @(negedge clk);
    check_hold(8'h03, 1'b0);

    // Bit stream A:1,0,1,0,0,1,0,1  B:1,1,1,1,0,0,0,0 (LSB first).
    op(8'hA5, 8'h0F, 8'hB4, 1'b0);

    // Reset during the 4th SHIFT cycle aborts with no done pulse.
    start = 1'b1; a = 8'h3C; b = 8'hC3;
    @(negedge clk);              // shift cycle 1
    start = 1'b0;
    repeat (3) @(negedge clk);   // shift cycle 4
    check("pre_abort_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_bit_valid", bit_valid, 1'b0);
    check("abort_bit_a", bit_a, 1'b0);
    check("abort_bit_b", bit_b, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("post_abort_done[%0d]", i), done, 1'b0);
      check($sformatf("post_abort_busy[%0d]", i), busy, 1'b0);
    end
    op(8'h3C, 8'hC3, 8'hFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
